// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register with valid/ready handshake, flush, bubble insertion and a stall counter.
// Define PIPE_STAGE_SKID_EN for a two-entry (main + skid) variant with a registered in_ready.
module pipe_stage_reg #(
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       CTRL_W   = 8,
    parameter logic [CTRL_W-1:0] NOP_CTRL = '0,
    parameter int unsigned       CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              out_valid_q, out_valid_d;
    logic [CTRL_W-1:0] out_ctrl_q,  out_ctrl_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic              accept;
    logic              leave;

    assign leave     = out_valid_q & out_ready;
    assign out_valid = out_valid_q;
    assign out_ctrl  = out_ctrl_q;
    assign out_data  = out_data_q;
    assign stall_cnt = stall_cnt_q;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid_q && !out_ready && !flush && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

`ifdef PIPE_STAGE_SKID_EN
    typedef enum logic [1:0] {ST_EMPTY, ST_BUSY, ST_FULL} state_t;

    state_t            state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;

    assign in_ready = in_ready_q;
    assign accept   = in_valid & in_ready_q;

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_ctrl_d  = out_ctrl_q;
        out_data_d  = out_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;
        if (flush) begin
            state_d     = ST_EMPTY;
            out_valid_d = 1'b0;
            out_ctrl_d  = NOP_CTRL;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d     = ST_BUSY;
                        out_valid_d = 1'b1;
                        out_ctrl_d  = in_ctrl;
                        out_data_d  = in_data;
                    end
                end
                ST_BUSY: begin
                    if (accept && leave) begin
                        out_ctrl_d = in_ctrl;
                        out_data_d = in_data;
                    end else if (accept) begin
                        state_d     = ST_FULL;
                        skid_ctrl_d = in_ctrl;
                        skid_data_d = in_data;
                    end else if (leave) begin
                        state_d     = ST_EMPTY;
                        out_valid_d = 1'b0;
                        out_ctrl_d  = NOP_CTRL;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so only the skid-to-main move can happen
                    if (leave) begin
                        state_d    = ST_BUSY;
                        out_ctrl_d = skid_ctrl_q;
                        out_data_d = skid_data_q;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
        in_ready_d = (state_d != ST_FULL);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_ctrl_q  <= NOP_CTRL;
            out_data_q  <= '0;
            skid_ctrl_q <= NOP_CTRL;
            skid_data_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_ctrl_q  <= out_ctrl_d;
            out_data_q  <= out_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end
`else
    assign in_ready = !out_valid_q | out_ready;
    assign accept   = in_valid & in_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        out_ctrl_d  = out_ctrl_q;
        out_data_d  = out_data_q;
        if (flush) begin
            out_valid_d = 1'b0;
            out_ctrl_d  = NOP_CTRL;
        end else if (accept) begin
            out_valid_d = 1'b1;
            out_ctrl_d  = in_ctrl;
            out_data_d  = in_data;
        end else if (leave) begin
            out_valid_d = 1'b0;
            out_ctrl_d  = NOP_CTRL;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            out_ctrl_q  <= NOP_CTRL;
            out_data_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_ctrl_q  <= out_ctrl_d;
            out_data_q  <= out_data_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end
`endif

endmodule
